hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Takes decoded control from ID/EX/MEM (MemRead, BranchEQ/BranchNE result, Jump) and drives stage write-enables, bubbles and flushes.
- Sequences three events: load-use stalls, taken-branch and jump squashes, and multi-cycle data-memory waits with timeout.
- Sits beside the control decoder; owns every pipeline-register enable.

Parameters:
LU_BUBBLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal 1..3
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before error; legal 2..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_uses_rt  in  1  ID instruction reads rt (R-type, BEQ, BNE, SW/SH/SB)
id_jump  in  1  Jump decoded in ID
ex_mem_read  in  1  EX stage instruction is LW/LH/LB
ex_rt  in  5  destination of the EX-stage load
mem_br_taken  in  1  branch in MEM resolved taken
mem_req  in  1  MEM stage issues data-memory access (MemRead|MemWrite)
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_bubble  out  1  ID/EX loads NOP control
ex_mem_flush  out  1  EX/MEM loads NOP control
pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
mem_err  out  1  sticky memory-timeout error
state  out  2  FSM state: 00 RUN, 01 LU_STALL, 10 MEM_WAIT, 11 ERR
stall_cnt  out  32  stall-cycle count (optional feature)
flush_cnt  out  32  flush-event count (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, counters=0, mem_err=0, out_en flop=0.
  - All outputs 0.
  - out_en sets on the first clk edge after release. pc_write, if_id_write and pipe_en are gated by out_en, so the PC does not advance on that edge.
- Outputs are Mealy: combinational from state plus inputs. State is registered. Decisions take effect at the same clk edge.
- Load-use hazard: lu = ex_mem_read & ex_rt!=0 & id_valid & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- RUN priority, highest first:
  1. mem_req & !mem_ready: all enables 0, flushes 0. Next state MEM_WAIT, tmo_cnt=1.
  2. mem_br_taken: if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1. Overrides lu and id_jump.
  3. lu: pc_write=0, if_id_write=0, id_ex_bubble=1. If LU_BUBBLES>1: next LU_STALL, lu_cnt=LU_BUBBLES-1.
  4. id_jump: if_id_flush=1, pc_write=1.
  5. Otherwise all enables 1, flushes 0.
- LU_STALL:
  - pc_write=0, if_id_write=0, id_ex_bubble=1. Hazard terms ignored.
  - lu_cnt decrements; at lu_cnt==1 the next state is RUN.
  - mem_req & !mem_ready takes priority: go to MEM_WAIT; lu_cnt is kept and LU_STALL resumes after the wait.
- MEM_WAIT:
  - pc_write=0, if_id_write=0, pipe_en=0. Branch, jump and hazard inputs ignored; they persist because the pipe is frozen.
  - mem_ready=1: next state is RUN, or LU_STALL if lu_cnt>0. Enables stay 0 this cycle; the MEM/WB capture is enabled on the following cycle.
  - tmo_cnt increments each cycle. When tmo_cnt==MEM_TIMEOUT and !mem_ready: next ERR.
  - mem_ready on the timeout cycle counts as success.
- ERR:
  - All enables 0, flushes 0, mem_err=1.
  - Held until rst_n asserted.
- Reset mid-operation: returns to RUN from any state within the same cycle. Counters and mem_err clear.
- Registers 0 are never hazard sources.

Optional Feature:
HAZ_PERF_CNT_EN defined:
- stall_cnt increments on every cycle with pc_write=0 and out_en=1, excluding ERR.
- flush_cnt increments on every cycle with if_id_flush=1.
- Both 32-bit, wrap at 2^32-1 to 0, cleared by reset.

HAZ_PERF_CNT_EN undefined:
- No counter logic.
- stall_cnt and flush_cnt tied to 0.

Test Plan:
- Reset, release, no hazards: pc_write=0 on the first edge, then 1 on every later cycle; state=00.
- ex_mem_read=1, ex_rt=5, id_rs=5, id_valid=1, LU_BUBBLES=2: two cycles pc_write=0 and id_ex_bubble=1, state 00→01→00. Repeat with ex_rt=0: no stall.
- Same cycle mem_br_taken=1, lu=1, id_jump=1: if_id_flush, id_ex_bubble and ex_mem_flush all 1; pc_write=1; no LU_STALL entry.
- mem_req=1, mem_ready raised after 3 cycles: pipe_en=0 for 4 cycles, state 10 for 3, then RUN.
- mem_req=1, mem_ready never, MEM_TIMEOUT=16: state 11 after 16 cycles, mem_err=1 held; rst_n pulse returns state 00 with mem_err 0.
- HAZ_PERF_CNT_EN: one LU_BUBBLES=1 stall plus one jump gives stall_cnt=1 and flush_cnt=1.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage MIPS core. Owns every pipeline-register
// enable and sequences load-use stalls, branch/jump squashes and data-memory
// waits with timeout.
//
// Optional feature macro: HAZ_PERF_CNT_EN adds the stall and flush event
// counters. Without it, stall_cnt_o and flush_cnt_o are tied to 0.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   id_*_i             ID-stage instruction: valid, rs, rt, reads-rt, jump
//   ex_mem_read_i      EX-stage instruction is a load
//   ex_rt_i            EX-stage load destination
//   mem_br_taken_i     branch in MEM resolved taken
//   mem_req_i          MEM stage issues a data-memory access
//   mem_ready_i        data memory completes the access this cycle
//   pc_write_o         PC update enable
//   if_id_write_o      IF/ID enable;  if_id_flush_o  IF/ID loads NOP
//   id_ex_bubble_o     ID/EX loads NOP control
//   ex_mem_flush_o     EX/MEM loads NOP control
//   pipe_en_o          enable for ID/EX, EX/MEM, MEM/WB
//   mem_err_o          sticky memory-timeout error
//   state_o            00 RUN, 01 LU_STALL, 10 MEM_WAIT, 11 ERR
//   stall_cnt_o        stall-cycle count
//   flush_cnt_o        flush-event count
module hazard_sequencer #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        id_jump_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        mem_br_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_flush_o,
  output logic        pipe_en_o,
  output logic        mem_err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StMemWait = 2'b10,
    StErr     = 2'b11
  } state_e;

  localparam logic [1:0] LuInit = 2'(LU_BUBBLES - 1);
  localparam logic [7:0] TmoMax = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       out_en_q;

  logic lu, mem_stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_en, mem_err;

  // Register 0 is never a hazard source.
  assign lu = ex_mem_read_i & (ex_rt_i != 5'd0) & id_valid_i &
              ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
  assign mem_stall = mem_req_i & ~mem_ready_i;

  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_en      = 1'b1;
    mem_err      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_en     = 1'b0;
          state_d     = StMemWait;
          tmo_cnt_d   = 8'd1;
        end else if (mem_br_taken_i) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (lu) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_d  = StLuStall;
            lu_cnt_d = LuInit;
          end
        end else if (id_jump_i) begin
          if_id_flush = 1'b1;
        end
      end
      StLuStall: begin
        if (mem_stall) begin
          // lu_cnt is kept so the remaining bubbles resume after the wait.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_en     = 1'b0;
          state_d     = StMemWait;
          tmo_cnt_d   = 8'd1;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          lu_cnt_d     = lu_cnt_q - 2'd1;
          if (lu_cnt_q == 2'd1) state_d = StRun;
        end
      end
      StMemWait: begin
        // Frozen pipe: hazard, branch and jump inputs simply persist.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_en     = 1'b0;
        if (mem_ready_i) begin
          state_d = (lu_cnt_q != 2'd0) ? StLuStall : StRun;
        end else if (tmo_cnt_q == TmoMax) begin
          state_d = StErr;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StErr: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_en     = 1'b0;
        mem_err     = 1'b1;
      end
      default: state_d = StErr;
    endcase

    // First cycle after reset release: everything held off, nothing advances.
    if (!out_en_q) begin
      state_d      = state_q;
      lu_cnt_d     = lu_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_en      = 1'b0;
      mem_err      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      lu_cnt_q  <= 2'd0;
      tmo_cnt_q <= 8'd0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lu_cnt_q  <= lu_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      out_en_q  <= 1'b1;
    end
  end

  assign pc_write_o     = pc_write;
  assign if_id_write_o  = if_id_write;
  assign if_id_flush_o  = if_id_flush;
  assign id_ex_bubble_o = id_ex_bubble;
  assign ex_mem_flush_o = ex_mem_flush;
  assign pipe_en_o      = pipe_en;
  assign mem_err_o      = mem_err;
  assign state_o        = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (out_en_q && !pc_write && (state_q != StErr)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule
